// File: rtl/evt_rx_tracker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// evt_rx_tracker_if : channel pulses, read-out handshake and tracker status
// Revision: 1.0
// ---------------------------------------------------------------------------
interface evt_rx_tracker_if #(
  parameter int N_CH  = 16,
  parameter int CNT_W = 16
) ();
  logic [N_CH-1:0]       din;
  logic [N_CH-1:0]       ch_en;
  logic                  evt_done;
  logic [N_CH*CNT_W-1:0] evt_rx;
  logic [CNT_W-1:0]      evt_tx;
  logic                  need_read;
  logic [N_CH-1:0]       ovf;
  logic                  underrun;
  logic                  stall;
  logic [N_CH-1:0]       stall_mask;

  modport master (
    output din, ch_en, evt_done,
    input  evt_rx, evt_tx, need_read, ovf, underrun, stall, stall_mask
  );

  modport slave (
    input  din, ch_en, evt_done,
    output evt_rx, evt_tx, need_read, ovf, underrun, stall, stall_mask
  );
endinterface
`default_nettype wire

// File: rtl/evt_rx_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// evt_rx_tracker : per-channel event counting, need_read, overflow and stall
// Revision: 1.0
// ---------------------------------------------------------------------------
module evt_rx_tracker #(
  parameter int N_CH    = 16,
  parameter int CNT_W   = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  evt_rx_tracker_if.slave   bus
);

  localparam int               TMR_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  logic [N_CH-1:0][CNT_W-1:0] rx_q, rx_d, occ_d;
  logic [CNT_W-1:0]           tx_q, tx_d;
  logic [N_CH-1:0]            nz_d, ovf_q, ovf_d;
  logic                       need_q, need_d;
  logic                       underrun_q, underrun_d;
  logic                       partial;
  state_t                     state_q, state_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       stall_q, stall_d;
  logic [N_CH-1:0]            mask_q, mask_d;

  // Everything below works on next-state counters so need_read moves on the
  // same edge as the counter update that causes it.
  assign tx_d = (bus.evt_done && need_q) ? tx_q + ONE : tx_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign rx_d[i]  = (bus.din[i] && bus.ch_en[i]) ? rx_q[i] + ONE : rx_q[i];
    assign occ_d[i] = rx_d[i] - tx_d;
    assign nz_d[i]  = |occ_d[i];
    assign ovf_d[i] = ovf_q[i] | (bus.ch_en[i] && (occ_d[i] > DEPTH_C));
  end

  assign need_d     = (|bus.ch_en) && (&(nz_d | ~bus.ch_en));
  assign underrun_d = underrun_q | (bus.evt_done && !need_q);
  assign partial    = (|(nz_d & bus.ch_en)) && !need_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    stall_d = stall_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (partial) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (!partial) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_MAX) begin
          state_d = ST_STALL;
          stall_d = 1'b1;
          mask_d  = bus.ch_en & ~nz_d;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STALL: begin
        if (need_d) begin
          state_d = ST_IDLE;
          stall_d = 1'b0;
          mask_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q       <= '0;
      tx_q       <= '0;
      need_q     <= 1'b0;
      ovf_q      <= '0;
      underrun_q <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      stall_q    <= 1'b0;
      mask_q     <= '0;
    end else begin
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      need_q     <= need_d;
      ovf_q      <= ovf_d;
      underrun_q <= underrun_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      stall_q    <= stall_d;
      mask_q     <= mask_d;
    end
  end

  assign bus.evt_rx     = rx_q;
  assign bus.evt_tx     = tx_q;
  assign bus.need_read  = need_q;
  assign bus.ovf        = ovf_q;
  assign bus.underrun   = underrun_q;
  assign bus.stall      = stall_q;
  assign bus.stall_mask = mask_q;

endmodule
`default_nettype wire

// File: doc/evt_rx_tracker.md
# evt_rx_tracker

Parametrised per-channel event-receive tracker for the readout path. It counts event-completion pulses (falling-edge pulses of each channel's data_wr_req) on N_CH channels and tracks the read-out event count from tx_manager internally. It drives need_read to tx_manager when every enabled channel holds at least one unread event. It adds channel masking, wrap-safe occupancy, per-channel overflow detection and a partial-arrival stall watchdog.

## Interface
Parameters:
- N_CH, 16, number of channels
- CNT_W, 16, width of every event counter; arithmetic is modulo 2^CNT_W
- DEPTH, 8, maximum unread events a channel buffer holds; must be 1..2^(CNT_W-1)
- TIMEOUT, 1024, cycles a partial arrival may persist before stall; must be ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- din  in  N_CH  one-cycle event-complete pulse per channel
- ch_en  in  N_CH  channel enable; a disabled channel neither counts nor gates need_read
- evt_done  in  1  one-cycle pulse from tx_manager: one event fully read out
- evt_rx  out  N_CH*CNT_W  per-channel receive counters; channel i at bits [i*CNT_W +: CNT_W]
- evt_tx  out  CNT_W  events read out
- need_read  out  1  to tx_manager: a complete event is available
- ovf  out  N_CH  sticky: channel occupancy exceeded DEPTH
- underrun  out  1  sticky: evt_done arrived while need_read=0
- stall  out  1  sticky until cleared: partial arrival exceeded TIMEOUT
- stall_mask  out  N_CH  enabled channels with zero occupancy, captured on stall entry

## Operation
- All outputs are registered. Reset values are 0 for every output and internal counter, and the FSM returns to IDLE. Reset has priority, so din and evt_done are ignored in the reset cycle.
- Counter update: evt_rx[i] increments by 1 when din[i] && ch_en[i], and wraps from 2^CNT_W-1 to 0. evt_tx increments when evt_done && need_read.
- evt_done && !need_read leaves evt_tx unchanged and sets underrun.
- Occupancy: occ[i] = (evt_rx[i] − evt_tx) mod 2^CNT_W, computed from next-state counter values. It is wrap-safe as long as occ ≤ 2^(CNT_W-1).
- need_read_next = (ch_en != 0) && for every i with ch_en[i], occ_next[i] ≥ 1.
- ovf[i] is set when ch_en[i] && occ_next[i] > DEPTH. It is cleared only by reset.
- A disabled channel's counter freezes. On re-enable, its occupancy is recomputed against the current evt_tx with no resync; firmware re-enables only after reset.
- Stall FSM. Let partial = some enabled channel has occ ≥ 1 && !need_read_next.
  - IDLE: on partial, go to WAIT with timer=0.
  - WAIT: while partial, timer increments. If !partial, go to IDLE. When timer reaches TIMEOUT−1 while still partial, go to STALL, set stall=1, and load stall_mask with the enabled channels whose occ_next=0.
  - STALL: stall and stall_mask hold. When need_read_next=1, go to IDLE and clear stall and stall_mask. Any other exit is by reset only.

## Timing
- Zero-cycle decision latency: need_read is updated on the same edge as the counters that cause it.
  - A din pulse sampled at edge k that completes the set raises need_read after edge k.
  - An evt_done sampled at edge k that empties a channel drops need_read after edge k.
- Simultaneous din[i] and evt_done in one cycle apply both, so occ[i] is unchanged.
- Multiple din bits may be high in the same cycle; each counts independently.
- Stall rises exactly TIMEOUT cycles after the first cycle in which partial is true, if partial holds continuously.
- Back-to-back evt_done pulses are accepted every cycle while need_read=1. Each one is evaluated against need_read as registered at that edge.

## Test plan
- N_CH=4, all enabled: pulse din=0001, 0010, 0100 on separate cycles → need_read=0. Pulse din=1000 → need_read=1 one edge later and evt_rx={1,1,1,1}. Then evt_done → evt_tx=1, need_read=0.
- ch_en=0101: pulse din[0] and din[2] only → need_read=1, and evt_rx[1] and evt_rx[3] stay 0 even when din[1] and din[3] pulse.
- CNT_W=4: preload via 15 full events with read-out, then one more full event → evt_rx wraps to 0, evt_tx=15, occ=1, need_read=1. Reading it gives evt_tx=0, need_read=0.
- DEPTH=2: pulse din[0] three times with no reads → ovf[0]=1 after the third edge, and it stays 1 after subsequent reads until reset.
- TIMEOUT=8: din=0011 only, with channels 2 and 3 silent → stall=1 exactly 8 cycles later and stall_mask=1100. Then din=1100 → need_read=1, stall=0, stall_mask=0.
- evt_done with need_read=0 → underrun=1 and evt_tx unchanged. Reset asserted alongside din=1111 → all outputs 0 and nothing counted.
